// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the parametrised UART transmitter.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } tx_state_e;

  localparam logic PAR_EVEN   = 1'b0;
  localparam logic PAR_ODD    = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  // Parity bit from the XOR-reduced data word and the requested sense.
  function automatic logic parity_bit(input logic data_xor, input logic par_type);
    return data_xor ^ (par_type == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO feeding the transmitter; full/empty/level are registered.
module uart_tx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           wr_en,
  input  logic [WIDTH-1:0]               wr_data,
  input  logic                           rd_en,
  output logic [WIDTH-1:0]               rd_data_c,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     level
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_ok_c;
  logic             rd_ok_c;
  logic [LW-1:0]    level_nxt_c;

  always_comb begin
    wr_ok_c     = wr_en && !full;
    rd_ok_c     = rd_en && !empty;
    level_nxt_c = level;
    if (wr_ok_c && !rd_ok_c) begin
      level_nxt_c = level + LW'(1);
    end else if (rd_ok_c && !wr_ok_c) begin
      level_nxt_c = level - LW'(1);
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (wr_ok_c) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok_c) rd_ptr <= rd_ptr + AW'(1);
      level <= level_nxt_c;
      full  <= (level_nxt_c == LW'(DEPTH));
      empty <= (level_nxt_c == '0);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST && wr_ok_c) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  assign rd_data_c = mem[rd_ptr];

endmodule

// File: rtl/uart_tx_param.sv
// UART transmitter with input FIFO, per-bit prescaler, optional parity and 1/2 stop bits.
module uart_tx_param
  import uart_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned PRESCALE_WIDTH = 8
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic [DATA_WIDTH-1:0]             P_Data,
  input  logic                              Data_valid,
  output logic                              Ready,
  input  logic                              Par_EN,
  input  logic                              Par_type,
  input  logic                              Stop_2,
  input  logic [PRESCALE_WIDTH-1:0]         Prescale,
  output logic                              TX_OUT,
  output logic                              Busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   Fifo_level
);

  localparam int unsigned BIT_W = $clog2(DATA_WIDTH);
  localparam int unsigned PW    = PRESCALE_WIDTH;

  tx_state_e            state;
  logic [PW-1:0]        cnt;
  logic [PW-1:0]        presc_q;
  logic [BIT_W-1:0]     bit_idx;
  logic [DATA_WIDTH-1:0] shreg;
  logic                 par_q;
  logic                 par_en_q;
  logic                 stop2_q;

  logic [DATA_WIDTH-1:0] fifo_rd_data_c;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [PW-1:0]        presc_eff_c;
  logic                 bit_end_c;
  logic                 last_stop_end_c;
  logic                 pop_c;

  uart_tx_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .wr_en     (Data_valid),
    .wr_data   (P_Data),
    .rd_en     (pop_c),
    .rd_data_c (fifo_rd_data_c),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (Fifo_level)
  );

  assign Ready = !fifo_full;

  // A pop starts a frame either from IDLE or seamlessly from the last stop cycle.
  always_comb begin
    presc_eff_c     = (Prescale == '0) ? PW'(1) : Prescale;
    bit_end_c       = (cnt == '0);
    last_stop_end_c = bit_end_c &&
                      (((state == STOP1) && !stop2_q) || (state == STOP2));
    pop_c           = !fifo_empty && ((state == IDLE) || last_stop_end_c);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state    <= IDLE;
      cnt      <= '0;
      presc_q  <= PW'(1);
      bit_idx  <= '0;
      shreg    <= '0;
      par_q    <= 1'b0;
      par_en_q <= 1'b0;
      stop2_q  <= 1'b0;
      TX_OUT   <= IDLE_LEVEL;
      Busy     <= 1'b0;
    end else if (pop_c) begin
      // Frame config is captured here and held until the next pop.
      state    <= START;
      cnt      <= presc_eff_c - PW'(1);
      presc_q  <= presc_eff_c;
      bit_idx  <= '0;
      shreg    <= fifo_rd_data_c;
      par_q    <= parity_bit(^fifo_rd_data_c, Par_type);
      par_en_q <= Par_EN;
      stop2_q  <= Stop_2;
      TX_OUT   <= ~IDLE_LEVEL;
      Busy     <= 1'b1;
    end else if (state != IDLE) begin
      if (!bit_end_c) begin
        cnt <= cnt - PW'(1);
      end else begin
        cnt <= presc_q - PW'(1);
        case (state)
          START: begin
            state   <= DATA;
            bit_idx <= '0;
            TX_OUT  <= shreg[0];
            shreg   <= shreg >> 1;
          end
          DATA: begin
            if (bit_idx == BIT_W'(DATA_WIDTH - 1)) begin
              if (par_en_q) begin
                state  <= PARITY;
                TX_OUT <= par_q;
              end else begin
                state  <= STOP1;
                TX_OUT <= IDLE_LEVEL;
              end
            end else begin
              bit_idx <= bit_idx + BIT_W'(1);
              TX_OUT  <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end
          PARITY: begin
            state  <= STOP1;
            TX_OUT <= IDLE_LEVEL;
          end
          STOP1: begin
            TX_OUT <= IDLE_LEVEL;
            if (stop2_q) begin
              state <= STOP2;
            end else begin
              state <= IDLE;
              Busy  <= 1'b0;
            end
          end
          STOP2: begin
            state  <= IDLE;
            TX_OUT <= IDLE_LEVEL;
            Busy   <= 1'b0;
          end
          default: begin
            state  <= IDLE;
            TX_OUT <= IDLE_LEVEL;
            Busy   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param: fixed frame table, corner sequences, random traffic.
module tb_uart_tx_param;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned PW    = 8;
  localparam int unsigned LW    = $clog2(DEPTH + 1);

  logic          CLK_tb = 1'b0;
  logic          rst;
  logic [DW-1:0] p_data;
  logic          data_valid;
  logic          ready;
  logic          par_en;
  logic          par_type;
  logic          stop_2;
  logic [PW-1:0] prescale;
  logic          tx_out;
  logic          busy;
  logic [LW-1:0] fifo_level;

  always #5 CLK_tb = ~CLK_tb;

  uart_tx_param #(
    .DATA_WIDTH     (DW),
    .FIFO_DEPTH     (DEPTH),
    .PRESCALE_WIDTH (PW)
  ) dut (
    .CLK        (CLK_tb),
    .RST        (rst),
    .P_Data     (p_data),
    .Data_valid (data_valid),
    .Ready      (ready),
    .Par_EN     (par_en),
    .Par_type   (par_type),
    .Stop_2     (stop_2),
    .Prescale   (prescale),
    .TX_OUT     (tx_out),
    .Busy       (busy),
    .Fifo_level (fifo_level)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int busy_cnt;
  int busy_rises;
  logic prev_busy;

  // Reference: queued words, and the line level for every remaining cycle of the current frame.
  logic          wave_q[$];
  logic [DW-1:0] word_q[$];

  typedef struct {
    logic [DW-1:0] data;
    logic          pe;
    logic          pt;
    logic          s2;
    logic [PW-1:0] presc;
    int            len;
    logic [15:0]   bits;
  } vec_t;

  vec_t tbl[5];

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic build_frame(input logic [DW-1:0] w);
    int p;
    logic bits[$];
    p = (prescale == '0) ? 1 : int'(prescale);
    bits.push_back(1'b0);
    for (int i = 0; i < int'(DW); i++) bits.push_back(w[i]);
    if (par_en) bits.push_back((^w) ^ par_type);
    bits.push_back(1'b1);
    if (stop_2) bits.push_back(1'b1);
    foreach (bits[i]) begin
      for (int k = 0; k < p; k++) wave_q.push_back(bits[i]);
    end
  endtask

  task automatic model_edge();
    int lvl_pre;
    if (!rst) begin
      wave_q.delete();
      word_q.delete();
    end else begin
      lvl_pre = word_q.size();
      if (wave_q.size() > 0) void'(wave_q.pop_front());
      if (wave_q.size() == 0 && lvl_pre > 0) build_frame(word_q.pop_front());
      if (data_valid && lvl_pre < int'(DEPTH)) word_q.push_back(p_data);
    end
  endtask

  task automatic track_busy();
    if (busy === 1'b1) busy_cnt++;
    if (busy === 1'b1 && prev_busy !== 1'b1) busy_rises++;
    prev_busy = busy;
  endtask

  task automatic clear_track();
    busy_cnt   = 0;
    busy_rises = 0;
    prev_busy  = busy;
  endtask

  task automatic tick();
    logic exp_tx;
    @(posedge CLK_tb);
    model_edge();
    cyc++;
    #1;
    exp_tx = (wave_q.size() > 0) ? wave_q[0] : 1'b1;
    check1("model_tx", 32'(tx_out), 32'(exp_tx));
    check1("model_busy", 32'(busy), 32'(wave_q.size() > 0));
    check1("model_ready", 32'(ready), 32'(word_q.size() < int'(DEPTH)));
    check1("model_level", 32'(fifo_level), 32'(word_q.size()));
    track_busy();
  endtask

  initial begin
    tbl[0] = '{data: 8'hA5, pe: 1'b1, pt: 1'b0, s2: 1'b0, presc: 8'd1, len: 11, bits: 16'h054A};
    tbl[1] = '{data: 8'hA5, pe: 1'b1, pt: 1'b1, s2: 1'b0, presc: 8'd1, len: 11, bits: 16'h074A};
    tbl[2] = '{data: 8'h3C, pe: 1'b0, pt: 1'b0, s2: 1'b1, presc: 8'd4, len: 11, bits: 16'h0678};
    tbl[3] = '{data: 8'h01, pe: 1'b0, pt: 1'b0, s2: 1'b0, presc: 8'd0, len: 10, bits: 16'h0202};
    tbl[4] = '{data: 8'hFF, pe: 1'b1, pt: 1'b1, s2: 1'b1, presc: 8'd3, len: 12, bits: 16'h0FFE};

    rst = 1'b0; p_data = '0; data_valid = 1'b0;
    par_en = 1'b0; par_type = 1'b0; stop_2 = 1'b0; prescale = 8'd1;
    prev_busy = 1'b0;
    tick();
    tick();
    check1("rst_tx", 32'(tx_out), 32'd1);
    check1("rst_busy", 32'(busy), 32'd0);
    check1("rst_ready", 32'(ready), 32'd1);
    check1("rst_level", 32'(fifo_level), 32'd0);
    rst = 1'b1;
    tick();

    // Fixed frames against hand-derived bit patterns.
    for (int r = 0; r < 5; r++) begin
      int p;
      par_en = tbl[r].pe; par_type = tbl[r].pt; stop_2 = tbl[r].s2; prescale = tbl[r].presc;
      p = (tbl[r].presc == '0) ? 1 : int'(tbl[r].presc);
      p_data = tbl[r].data; data_valid = 1'b1;
      tick();
      data_valid = 1'b0;
      for (int c = 0; c < tbl[r].len * p; c++) begin
        tick();
        check1("tbl_tx", 32'(tx_out), 32'(tbl[r].bits[c / p]));
        check1("tbl_busy", 32'(busy), 32'd1);
      end
      tick();
      check1("tbl_end_tx", 32'(tx_out), 32'd1);
      check1("tbl_end_busy", 32'(busy), 32'd0);
    end

    // Six back-to-back pushes: fill, drop the sixth, five seamless frames.
    prescale = 8'd1; par_en = 1'b1; par_type = 1'b0; stop_2 = 1'b0;
    clear_track();
    for (int i = 0; i < 6; i++) begin
      p_data = 8'h10 + 8'(i * 17); data_valid = 1'b1;
      tick();
      if (i == 1) begin
        check1("b2b_first_pop_level", 32'(fifo_level), 32'd1);
        check1("b2b_first_pop_tx", 32'(tx_out), 32'd0);
      end
      if (i == 4) begin
        check1("b2b_full_level", 32'(fifo_level), 32'd4);
        check1("b2b_full_ready", 32'(ready), 32'd0);
      end
    end
    data_valid = 1'b0;
    for (int i = 0; i < 70; i++) tick();
    check1("b2b_busy_cycles", 32'(busy_cnt), 32'd55);
    check1("b2b_busy_rises", 32'(busy_rises), 32'd1);

    // Reset in the middle of DATA with a word still queued.
    prescale = 8'd2; par_en = 1'b0; stop_2 = 1'b0;
    p_data = 8'h5A; data_valid = 1'b1; tick();
    p_data = 8'hC3; tick();
    data_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    rst = 1'b0;
    tick();
    check1("midrst_tx", 32'(tx_out), 32'd1);
    check1("midrst_busy", 32'(busy), 32'd0);
    check1("midrst_level", 32'(fifo_level), 32'd0);
    rst = 1'b1;
    clear_track();
    for (int i = 0; i < 20; i++) tick();
    check1("midrst_quiet", 32'(busy_cnt), 32'd0);

    // Config change mid-frame only affects the following frame.
    prescale = 8'd1; par_en = 1'b1; stop_2 = 1'b1;
    clear_track();
    p_data = 8'h96; data_valid = 1'b1; tick();
    p_data = 8'h4B; tick();
    data_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    par_en = 1'b0; stop_2 = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    check1("cfg_busy_cycles", 32'(busy_cnt), 32'd22);
    check1("cfg_busy_rises", 32'(busy_rises), 32'd1);

    // Random traffic, config churn and occasional resets against the reference.
    for (int i = 0; i < 600; i++) begin
      rst        = ($urandom_range(0, 199) != 0);
      data_valid = ($urandom_range(0, 3) == 0);
      p_data     = DW'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        par_en   = 1'($urandom);
        par_type = 1'($urandom);
        stop_2   = 1'($urandom);
        prescale = PW'($urandom_range(0, 3));
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
